// File: rtl/queue_arb_pkg.sv
// queue_arb_pkg: shared widths, requester id and occupancy types for the queue write arbiter
package queue_arb_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_id_t;
  typedef logic [ADDR_W:0] count_t;
endpackage

// File: rtl/queue_store.sv
// queue_store: DEPTH x DATA_W byte array with one sync write port and one registered read port
module queue_store
  import queue_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  // read register holds its last value between pops
  always_comb rdata_d = re ? mem[raddr] : rdata_q;
  // storage array is never reset; emptiness is tracked by the owner
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  // registered read data
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/queue_write_arbiter.sv
// queue_write_arbiter: two-requester write arbiter with pointers/count over a shared byte queue; define QUEUE_ARB_ROUND_ROBIN_EN for round-robin contention, else requester 0 has fixed priority
module queue_write_arbiter
  import queue_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              grant_id
);
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  count_t            count_q, count_d;
  req_id_t           grant_id_q, grant_id_d, last_grant_q, last_grant_d, winner;
  logic              rd_valid_q, rd_valid_d, wr, rd;
  logic [DATA_W-1:0] wr_data;
  assign full  = count_q == count_t'(DEPTH);
  assign empty = count_q == '0;
  // pick the requester that owns the write port this cycle
  always_comb begin
`ifdef QUEUE_ARB_ROUND_ROBIN_EN
    winner = (req0_valid && req1_valid) ? req_id_t'(~last_grant_q) : (req1_valid ? REQ1 : REQ0);
`else
    winner = (req1_valid && !req0_valid) ? REQ1 : REQ0;
`endif
  end
  // handshakes, pointer/count/grant next-state; full blocks writes, empty blocks reads
  always_comb begin
    wr           = (req0_valid || req1_valid) && !full;
    rd           = rd_en && !empty;
    req0_ready   = wr && winner == REQ0;
    req1_ready   = wr && winner == REQ1;
    wr_data      = winner == REQ1 ? req1_data : req0_data;
    wr_ptr_d     = wr ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d     = rd ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d      = (wr && !rd) ? count_q + count_t'(1) : (rd && !wr) ? count_q - count_t'(1) : count_q;
    grant_id_d   = wr ? winner : grant_id_q;
    last_grant_d = wr ? winner : last_grant_q;
    rd_valid_d   = rd;
  end
  // state registers; last_grant resets to REQ1 so REQ0 wins the first contention
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      grant_id_q   <= REQ0;
      last_grant_q <= REQ1;
      rd_valid_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      rd_valid_q   <= rd_valid_d;
    end
  queue_store u_store (
    .clk   (clk),
    .rst   (rst),
    .we    (wr),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (rd),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );
  assign count    = count_q;
  assign rd_valid = rd_valid_q;
  assign grant_id = grant_id_q;
endmodule

// File: tb/tb_queue_write_arbiter.sv
// tb_queue_write_arbiter: directed self-checking bench; expectations follow QUEUE_ARB_ROUND_ROBIN_EN when defined
module tb_queue_write_arbiter;
  logic       clk = 0, rst = 0;
  logic       req0_valid = 0, req1_valid = 0, rd_en = 0;
  logic [7:0] req0_data = 0, req1_data = 0;
  logic       req0_ready, req1_ready, rd_valid, full, empty, grant_id;
  logic [7:0] rd_data;
  logic [4:0] count;
  int checks = 0, errors = 0;
  queue_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .full(full), .empty(empty), .grant_id(grant_id)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; rd_en = 0;
    rst = 1;
    step();
    step();
    rst = 0;
  endtask
  task automatic test_reset();
    req0_valid = 0; req1_valid = 0; rd_en = 0;
    rst = 1;
    #1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00 || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d empty=%b full=%b rd_valid=%b rd_data=%h grant=%b, want 0 1 0 0 00 0", count, empty, full, rd_valid, rd_data, grant_id);
    end
    step();
    rst = 0;
    req1_valid = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_follow: r0=%b r1=%b, want 0 1", req0_ready, req1_ready);
    end
    req1_valid = 0;
    do_reset();
  endtask
  task automatic test_single();
    logic [7:0] exp;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1; req0_data = 8'h11 * (i + 1);
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL single_ready[%0d]: r0=%b r1=%b, want 1 0", i, req0_ready, req1_ready);
      end
      step();
    end
    req0_valid = 0;
    checks++;
    if (count !== 5'd3) begin
      errors++;
      $display("FAIL single_count: got %0d want 3", count);
    end
    rd_en = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp = 8'h11 * (i + 1);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        errors++;
        $display("FAIL single_read[%0d]: valid=%b data=%h, want 1 %h", i, rd_valid, rd_data, exp);
      end
    end
    rd_en = 0;
    step();
    checks++;
    if (rd_valid !== 1'b0 || empty !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("FAIL single_drain: valid=%b empty=%b count=%0d, want 0 1 0", rd_valid, empty, count);
    end
  endtask
  task automatic test_contention();
    logic [7:0] exp_data [4];
    logic       exp_id;
    do_reset();
    req0_valid = 1; req1_valid = 1; req0_data = 8'hA0; req1_data = 8'hB0;
    for (int i = 0; i < 4; i++) begin
`ifdef QUEUE_ARB_ROUND_ROBIN_EN
      exp_id = i[0];
`else
      exp_id = 1'b0;
`endif
      exp_data[i] = exp_id ? 8'hB0 : 8'hA0;
      #1;
      checks++;
      if (req0_ready !== ~exp_id || req1_ready !== exp_id) begin
        errors++;
        $display("FAIL contention_ready[%0d]: r0=%b r1=%b, want %b %b", i, req0_ready, req1_ready, ~exp_id, exp_id);
      end
      step();
      checks++;
      if (grant_id !== exp_id) begin
        errors++;
        $display("FAIL contention_grant[%0d]: got %b want %b", i, grant_id, exp_id);
      end
    end
    req0_valid = 0; req1_valid = 0;
    rd_en = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (rd_data !== exp_data[i]) begin
        errors++;
        $display("FAIL contention_order[%0d]: got %h want %h", i, rd_data, exp_data[i]);
      end
    end
    rd_en = 0;
    step();
  endtask
  task automatic test_full();
    do_reset();
    req0_valid = 1;
    for (int i = 0; i < 16; i++) begin
      req0_data = 8'(i + 1);
      step();
    end
    req1_valid = 1;
    #1;
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state: full=%b count=%0d r0=%b r1=%b, want 1 16 0 0", full, count, req0_ready, req1_ready);
    end
    req0_valid = 0; req1_data = 8'hEE; rd_en = 1;
    #1;
    checks++;
    if (req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_write_block: r1=%b want 0", req1_ready);
    end
    step();
    req1_valid = 0; rd_en = 0;
    checks++;
    if (count !== 5'd15 || full !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 8'h01) begin
      errors++;
      $display("FAIL full_read: count=%0d full=%b valid=%b data=%h, want 15 0 1 01", count, full, rd_valid, rd_data);
    end
  endtask
  task automatic test_wrap();
    int bad = 0;
    do_reset();
    req0_valid = 1;
    for (int i = 0; i < 16; i++) begin
      req0_data = 8'(8'h40 + i);
      step();
    end
    req0_valid = 0; rd_en = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (rd_data !== 8'(8'h40 + i)) bad++;
    end
    rd_en = 0;
    checks++;
    if (bad != 0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_drain: bad_reads=%0d empty=%b, want 0 1", bad, empty);
    end
    req0_valid = 1; req0_data = 8'h5A;
    step();
    req0_valid = 0;
    checks++;
    if (dut.u_store.mem[0] !== 8'h5A || count !== 5'd1) begin
      errors++;
      $display("FAIL wrap_index0: mem0=%h count=%0d, want 5a 1", dut.u_store.mem[0], count);
    end
    rd_en = 1;
    step();
    rd_en = 0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin
      errors++;
      $display("FAIL wrap_read: valid=%b data=%h, want 1 5a", rd_valid, rd_data);
    end
  endtask
  task automatic test_empty_bypass();
    do_reset();
    rd_en = 1; req0_valid = 1; req0_data = 8'h77;
    step();
    req0_valid = 0;
    checks++;
    if (rd_valid !== 1'b0 || count !== 5'd1) begin
      errors++;
      $display("FAIL empty_no_bypass: valid=%b count=%0d, want 0 1", rd_valid, count);
    end
    step();
    rd_en = 0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h77 || count !== 5'd0) begin
      errors++;
      $display("FAIL empty_then_read: valid=%b data=%h count=%0d, want 1 77 0", rd_valid, rd_data, count);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    req1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      req1_data = 8'(8'h90 + i);
      step();
    end
    req1_valid = 0; rd_en = 1;
    step();
    checks++;
    if (rd_valid !== 1'b1 || count !== 5'd5 || grant_id !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: valid=%b count=%0d grant=%b, want 1 5 1", rd_valid, count, grant_id);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: count=%0d empty=%b valid=%b, want 0 1 0", count, empty, rd_valid);
    end
    step();
    rst = 0;
    rd_en = 0; req0_valid = 1; req1_valid = 1; req0_data = 8'hC0; req1_data = 8'hD0;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_first_contention: r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
    end
    step();
    req0_valid = 0; req1_valid = 0;
    checks++;
    if (grant_id !== 1'b0 || count !== 5'd1) begin
      errors++;
      $display("FAIL mid_grant: grant=%b count=%0d, want 0 1", grant_id, count);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_wrap();
    test_empty_bypass();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/queue_write_arbiter.md
# queue_write_arbiter

Shares a single 16-entry, 8-bit circular buffer between two independent write requesters and one reader. Arbitrates write access per cycle, owns the write/read pointers and occupancy count, and returns registered read data. Sits in front of the byte-queue storage so that upstream producers never drive the array directly.

## Interface
- DATA_W, 8, payload width
- DEPTH, 16, buffer entries (power of two)
- ADDR_W, 4, log2(DEPTH)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has a byte
- req0_data  in  DATA_W  requester 0 byte
- req0_ready  out  1  requester 0 byte accepted this cycle
- req1_valid  in  1  requester 1 has a byte
- req1_data  in  DATA_W  requester 1 byte
- req1_ready  out  1  requester 1 byte accepted this cycle
- rd_en  in  1  pop request
- rd_data  out  DATA_W  popped byte, registered
- rd_valid  out  1  rd_data valid, one-cycle pulse
- count  out  ADDR_W+1  occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- grant_id  out  1  requester that won the last accepted write

## Operation
- Write accept: reqN_ready = grant to N && reqN_valid && !full; combinational from current state and valids. At most one ready high per cycle.
- Arbitration: both valid -> winner per Configuration; one valid -> that one wins; none -> no write.
- Accepted write: mem[wr_ptr] <= data, wr_ptr <= wr_ptr+1 (wraps DEPTH-1 -> 0), grant_id <= winner, last_grant <= winner.
- Read: rd_en && !empty -> rd_data <= mem[rd_ptr], rd_valid <= 1, rd_ptr wraps like wr_ptr. rd_en while empty ignored, rd_valid <= 0, no error flag.
- Count: +1 on write only, -1 on read only, unchanged on simultaneous write+read.
- Full blocks writes even if a read occurs the same cycle (no write-through-full).
- Empty blocks reads even if a write occurs the same cycle (no bypass).
- full/empty combinational from count.

## Timing
- Write accepted in same cycle ready is high; visible in count next cycle.
- Read latency 1: rd_en at edge N -> rd_data/rd_valid valid after edge N+1, for one cycle.
- Write-to-read: byte written at edge N is readable by rd_en sampled at edge N+1.
- Reset values: wr_ptr 0, rd_ptr 0, count 0, rd_data 0, rd_valid 0, grant_id 0, last_grant 1 (requester 0 wins first contention). full 0, empty 1, both ready follow valids.
- Reset mid-operation: all state cleared immediately; buffer contents undefined but unreadable (empty=1). In-flight rd_valid dropped.

## Configuration
- QUEUE_ARB_ROUND_ROBIN_EN defined: on contention, winner = !last_grant (alternate).
- Not defined: fixed priority, requester 0 always wins contention; last_grant still tracked, grant_id still reported.

## Structure
- Package queue_arb_pkg: DATA_W, DEPTH, ADDR_W constants; typedef req_id_t (1-bit enum REQ0/REQ1); typedef count_t [ADDR_W:0].
- Sub-module queue_store: DEPTH x DATA_W array, one synchronous write port, one registered read port; no reset on the array.
- Arbiter, pointers and count in the top module.

## Test plan
- Reset, then req0 writes 0x11,0x22,0x33 alone -> req0_ready high 3 cycles, count 3; three rd_en -> rd_data 0x11,0x22,0x33 each one cycle after rd_en.
- Both valid continuously, data 0xA0/0xB0 -> RR build: accepted order REQ0,REQ1,REQ0,REQ1; fixed build: REQ0 every cycle, req1_ready stays 0.
- Fill 16 entries -> full=1, count 16, both ready 0; rd_en + req1_valid same cycle -> read occurs, write refused, count 15.
- Wrap: write 16, read 16, write 0x5A -> stored at index 0, rd_data 0x5A after one rd_en.
- rd_en on empty with simultaneous write 0x77 -> rd_valid 0, count 1; next rd_en -> 0x77.
- Assert rst mid-stream with count 5 and rd_en pending -> count 0, empty 1, rd_valid 0 immediately; first contention after release grants REQ0.
